udma_tx_ch_arbiter: RTL
=======================

Name: udma_tx_ch_arbiter

Overview:
- Parametrised L2 read arbiter for the uDMA TX path: N_CH channel request ports share one L2 read port.
- Supports round-robin arbitration plus a per-channel high-priority class.
- Tracks up to MAX_OUTST read transactions in flight and returns each response to its originating channel, aligned by datasize.
- Sits between the TX channel logic (linear/external/stream) and the L2 interconnect.

Parameters:
N_CH, 12, number of requesting channels (>=2)
L2_DATA_WIDTH, 64, L2 read data width (fixed 64 in this generation)
L2_AWIDTH_NOAL, 16, channel address width (byte address)
DATA_WIDTH, 32, channel data width
MAX_OUTST, 4, max granted-but-not-delivered transactions (power of 2, >=2)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
cfg_hiprio_i  in  N_CH  per-channel high-priority mask
ch_req_i  in  N_CH  channel read request
ch_addr_i  in  N_CH*L2_AWIDTH_NOAL  channel byte address
ch_datasize_i  in  N_CH*2  00 byte, 01 half, 10/11 word
ch_gnt_o  out  N_CH  request accepted
ch_valid_o  out  N_CH  response data valid
ch_data_o  out  N_CH*DATA_WIDTH  response data (shared bus, replicated per slice)
ch_ready_i  in  N_CH  channel accepts response
l2_req_o  out  1  L2 read request
l2_gnt_i  in  1  L2 grant
l2_addr_o  out  32  L2 address
l2_rdata_i  in  L2_DATA_WIDTH  L2 read data
l2_rvalid_i  in  1  L2 read data valid
outst_o  out  clog2(MAX_OUTST)+1  current credit usage
err_o  out  1  sticky protocol error

Behaviour:
- Reset (rst_i=1 at clock edge): l2_req_o=0, ch_gnt_o=0, ch_valid_o=0, ch_data_o=0, outst_o=0, err_o=0. RR pointer=0. Lock cleared. Tag FIFO and response FIFO emptied. Reset mid-transaction discards all in-flight state; later l2_rvalid_i with an empty tag FIFO sets err_o.
- Credits: counter cnt increments on l2_req_o&l2_gnt_i and decrements on a response pop (valid&ready). Both in the same cycle leave cnt unchanged. outst_o=cnt.
- Request enable: l2_req_o asserted only when cnt<MAX_OUTST and (lock set or any ch_req_i set).
- Arbitration, combinational when unlocked:
  - If any requesting channel has cfg_hiprio_i=1, the candidate set is the requesting hiprio channels; otherwise it is all requesting channels.
  - Winner is the first candidate at index >= RR pointer, wrapping modulo N_CH.
- Lock: if l2_req_o=1 and l2_gnt_i=0, the winner index is registered and held. l2_req_o and l2_addr_o stay stable until the grant. Changes to ch_req_i or cfg_hiprio_i while locked are ignored.
- On grant (l2_req_o&l2_gnt_i):
  - ch_gnt_o[sel]=1 in the same cycle; at most one ch_gnt_o bit set.
  - RR pointer <= (sel+1) mod N_CH.
  - Lock cleared.
  - Push tag {sel, addr[2:0], datasize} into the tag FIFO (depth MAX_OUTST).
- l2_addr_o = zero-extend({ch_addr[sel][AW-1:3],3'b000}) to 32 bits.
- On l2_rvalid_i (earliest one cycle after the grant):
  - Pop the tag.
  - Select 32-bit lane by addr[2].
  - byte: lane >> (addr[1:0]*8), zero-extended to 8 bits.
  - half: lane >> (addr[1]*16), zero-extended to 16 bits.
  - word: lane.
  - Push {id, data} into the response FIFO (depth MAX_OUTST). The credit scheme guarantees no overflow.
  - l2_rvalid_i with an empty tag FIFO: ignore and set err_o (sticky until reset).
- Delivery: response FIFO head drives ch_valid_o[id]=1 (all other bits 0) and ch_data_o on every slice. Pop when ch_ready_i[id]=1.
  - Head-of-line blocking is by design: responses return in issue order.
  - Fully registered FIFO path: data is visible at ch_valid_o no earlier than the cycle after l2_rvalid_i.
- Full/empty:
  - cnt==MAX_OUTST forces l2_req_o=0, even when locked; the lock is retained.
  - A response FIFO push and pop in the same cycle are both honoured.
- Throughput: one grant per cycle and one delivery per cycle sustained when cnt<MAX_OUTST.

Test Plan:
- N_CH=4, channels 0,2 request continuously, l2_gnt_i=1, rvalid 1 cycle later, ready=1 -> grants alternate 0,2,0,2. outst_o stays <=2.
- cfg_hiprio_i=4'b1000, ch 0..3 all requesting -> ch3 granted every cycle while requesting; ch0 granted only after ch3 drops.
- ch1 req addr 0x0006, datasize 01, rdata 0x1122334455667788 -> ch_valid_o[1] with ch_data_o=0x00001122. Repeat with addr 0x0003, datasize 00 -> 0x00000055.
- l2_gnt_i held 0 for 5 cycles while ch0 requests, then ch2 raises req -> l2_addr_o stable and ch0 granted first.
- ch_ready_i=0, MAX_OUTST=4, ch0 requesting -> exactly 4 grants, then l2_req_o=0. Raising ready lets one grant resume per pop.
- Pulse rst_i with 2 transactions in flight, then drive l2_rvalid_i -> outputs zero after reset, and err_o=1 on the stray rvalid.

Source files
------------

// File: rtl/udma_tx_ch_arbiter.sv
// L2 read arbiter for the uDMA TX path.
// N_CH channels share one L2 read port. Arbitration is round-robin with a
// per-channel high-priority class. A tag FIFO tracks in-flight reads. A
// registered response FIFO returns aligned data to the originating channel
// in issue order.

module udma_tx_ch_arbiter #(
  parameter int unsigned N_CH           = 12,
  parameter int unsigned L2_DATA_WIDTH  = 64,
  parameter int unsigned L2_AWIDTH_NOAL = 16,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MAX_OUTST      = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [N_CH-1:0]                cfg_hiprio_i,
  input  logic [N_CH-1:0]                ch_req_i,
  input  logic [N_CH*L2_AWIDTH_NOAL-1:0] ch_addr_i,
  input  logic [N_CH*2-1:0]              ch_datasize_i,
  output logic [N_CH-1:0]                ch_gnt_o,
  output logic [N_CH-1:0]                ch_valid_o,
  output logic [N_CH*DATA_WIDTH-1:0]     ch_data_o,
  input  logic [N_CH-1:0]                ch_ready_i,
  output logic                           l2_req_o,
  input  logic                           l2_gnt_i,
  output logic [31:0]                    l2_addr_o,
  input  logic [L2_DATA_WIDTH-1:0]       l2_rdata_i,
  input  logic                           l2_rvalid_i,
  output logic [$clog2(MAX_OUTST):0]     outst_o,
  output logic                           err_o
);

  localparam int unsigned ChW    = $clog2(N_CH);
  localparam int unsigned ChW1   = ChW + 1;
  localparam int unsigned PtrW   = $clog2(MAX_OUTST);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned AW     = L2_AWIDTH_NOAL;
  localparam logic [ChW:0]      NChW   = ChW1'(N_CH);
  localparam logic [ChW-1:0]    LastCh = ChW'(N_CH - 1);
  localparam logic [CntW-1:0]   MaxCnt = CntW'(MAX_OUTST);

  // Arbitration state
  logic [ChW-1:0]      r_rr_ptr;
  logic                r_lock;
  logic [ChW-1:0]      r_lock_sel;
  logic [CntW-1:0]     r_cnt;
  logic                r_err;

  // Tag FIFO: one entry per granted read that has not returned yet
  logic [ChW-1:0]      r_tag_id   [MAX_OUTST];
  logic [2:0]          r_tag_off  [MAX_OUTST];
  logic [1:0]          r_tag_ds   [MAX_OUTST];
  logic [PtrW:0]       r_tag_wptr;
  logic [PtrW:0]       r_tag_rptr;

  // Response FIFO: aligned data waiting for the channel to accept it
  logic [ChW-1:0]        r_rsp_id   [MAX_OUTST];
  logic [DATA_WIDTH-1:0] r_rsp_data [MAX_OUTST];
  logic [PtrW:0]         r_rsp_wptr;
  logic [PtrW:0]         r_rsp_rptr;

  logic [N_CH-1:0]     w_hi_req;
  logic [N_CH-1:0]     w_cand;
  logic [2*N_CH-1:0]   w_cand2;
  logic [N_CH-1:0]     w_rot;
  logic                w_found;
  logic [ChW-1:0]      w_off;
  logic [ChW:0]        w_sum;
  logic [ChW-1:0]      w_arb_sel;
  logic [ChW-1:0]      w_sel;
  logic [AW-1:0]       w_addr;
  logic [1:0]          w_ds;
  logic                w_grant;

  logic                w_tag_empty;
  logic                w_tag_pop;
  logic [PtrW-1:0]     w_tag_ridx;
  logic [ChW-1:0]      w_pop_id;
  logic [2:0]          w_pop_off;
  logic [1:0]          w_pop_ds;
  logic [31:0]         w_lane;
  logic [31:0]         w_shift_b;
  logic [31:0]         w_shift_h;
  logic [31:0]         w_ext;

  logic                w_rsp_empty;
  logic                w_rsp_pop;
  logic [PtrW-1:0]     w_rsp_ridx;
  logic [ChW-1:0]      w_head_id;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic                w_head_ready;

  // Rotating priority search: rotate candidates so the RR pointer sits at bit 0,
  // take the lowest set bit, then rotate the offset back into a channel index.
  always_comb begin
    w_hi_req  = ch_req_i & cfg_hiprio_i;
    w_cand    = (|w_hi_req) ? w_hi_req : ch_req_i;
    w_cand2   = {w_cand, w_cand} >> r_rr_ptr;
    w_rot     = w_cand2[N_CH-1:0];
    w_found   = 1'b0;
    w_off     = '0;
    for (int unsigned j = 0; j < N_CH; j++) begin
      if (!w_found && w_rot[j]) begin
        w_found = 1'b1;
        w_off   = ChW'(j);
      end
    end
    w_sum     = {1'b0, r_rr_ptr} + {1'b0, w_off};
    w_arb_sel = (w_sum >= NChW) ? ChW'(w_sum - NChW) : ChW'(w_sum);
  end

  // Request/grant generation; a held lock overrides the live arbitration result
  always_comb begin
    w_sel  = r_lock ? r_lock_sel : w_arb_sel;
    w_addr = '0;
    w_ds   = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (w_sel == ChW'(i)) begin
        w_addr = ch_addr_i[i*AW +: AW];
        w_ds   = ch_datasize_i[i*2 +: 2];
      end
    end
    l2_req_o  = (r_cnt < MaxCnt) && (r_lock || (|ch_req_i));
    w_grant   = l2_req_o && l2_gnt_i;
    l2_addr_o = 32'({w_addr[AW-1:3], 3'b000});
    ch_gnt_o  = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      ch_gnt_o[i] = w_grant && (w_sel == ChW'(i));
    end
  end

  // Lock, round-robin pointer, credit counter and sticky error
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_lock     <= 1'b0;
      r_lock_sel <= '0;
      r_rr_ptr   <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_grant) begin
        r_lock   <= 1'b0;
        r_rr_ptr <= (w_sel == LastCh) ? '0 : w_sel + ChW'(1);
      end else if (l2_req_o && !r_lock) begin
        // Stalled request: freeze the winner so address stays stable
        r_lock     <= 1'b1;
        r_lock_sel <= w_arb_sel;
      end
      case ({w_grant, w_rsp_pop})
        2'b10:   r_cnt <= r_cnt + CntW'(1);
        2'b01:   r_cnt <= r_cnt - CntW'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (l2_rvalid_i && w_tag_empty) begin
        r_err <= 1'b1;
      end
    end
  end

  // Tag FIFO read side and datasize alignment of the returning beat
  always_comb begin
    w_tag_empty = (r_tag_wptr == r_tag_rptr);
    w_tag_pop   = l2_rvalid_i && !w_tag_empty;
    w_tag_ridx  = r_tag_rptr[PtrW-1:0];
    w_pop_id    = r_tag_id[w_tag_ridx];
    w_pop_off   = r_tag_off[w_tag_ridx];
    w_pop_ds    = r_tag_ds[w_tag_ridx];
    w_lane      = w_pop_off[2] ? l2_rdata_i[63:32] : l2_rdata_i[31:0];
    w_shift_b   = w_lane >> {w_pop_off[1:0], 3'b000};
    w_shift_h   = w_lane >> {w_pop_off[1], 4'b0000};
    case (w_pop_ds)
      2'b00:   w_ext = {24'h0, w_shift_b[7:0]};
      2'b01:   w_ext = {16'h0, w_shift_h[15:0]};
      default: w_ext = w_lane;
    endcase
  end

  // Tag FIFO pointers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tag_wptr <= '0;
      r_tag_rptr <= '0;
    end else begin
      if (w_grant) begin
        r_tag_wptr <= r_tag_wptr + 1'b1;
      end
      if (w_tag_pop) begin
        r_tag_rptr <= r_tag_rptr + 1'b1;
      end
    end
  end

  // Tag FIFO storage; contents are only meaningful between the pointers
  always_ff @(posedge clk_i) begin
    if (w_grant) begin
      r_tag_id[r_tag_wptr[PtrW-1:0]]  <= w_sel;
      r_tag_off[r_tag_wptr[PtrW-1:0]] <= w_addr[2:0];
      r_tag_ds[r_tag_wptr[PtrW-1:0]]  <= w_ds;
    end
  end

  // Response FIFO head decode and per-channel delivery outputs
  always_comb begin
    w_rsp_empty  = (r_rsp_wptr == r_rsp_rptr);
    w_rsp_ridx   = r_rsp_rptr[PtrW-1:0];
    w_head_id    = r_rsp_id[w_rsp_ridx];
    w_head_data  = r_rsp_data[w_rsp_ridx];
    w_head_ready = 1'b0;
    ch_valid_o   = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (w_head_id == ChW'(i)) begin
        w_head_ready  = ch_ready_i[i];
        ch_valid_o[i] = !w_rsp_empty;
      end
    end
    w_rsp_pop = !w_rsp_empty && w_head_ready;
    ch_data_o = w_rsp_empty ? '0 : {N_CH{w_head_data}};
    outst_o   = r_cnt;
    err_o     = r_err;
  end

  // Response FIFO pointers; push and pop may happen together
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rsp_wptr <= '0;
      r_rsp_rptr <= '0;
    end else begin
      if (w_tag_pop) begin
        r_rsp_wptr <= r_rsp_wptr + 1'b1;
      end
      if (w_rsp_pop) begin
        r_rsp_rptr <= r_rsp_rptr + 1'b1;
      end
    end
  end

  // Response FIFO storage
  always_ff @(posedge clk_i) begin
    if (w_tag_pop) begin
      r_rsp_id[r_rsp_wptr[PtrW-1:0]]   <= w_pop_id;
      r_rsp_data[r_rsp_wptr[PtrW-1:0]] <= DATA_WIDTH'(w_ext);
    end
  end

endmodule
